// File: rtl/rf_write_arbiter_pkg.sv
// Shared CPU definitions for the register-file write path: requester count,
// register/data widths, arbiter state encoding and the pending-bit decode.
package rf_write_arbiter_pkg;

    localparam int NUM_REQ  = 2;
    localparam int RD_W     = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << RD_W;

    // Last requester that won a grant; LAST1 after reset so requester 0
    // wins the first contention.
    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } last_e;

    // Single-entry output stage between the arbiter and the register file.
    typedef struct packed {
        logic              valid;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } stage_t;

    // One-hot decode of a destination register; x0 never marks anything.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [RD_W-1:0] rd);
        rd_onehot = '0;
        if (rd != '0) begin
            rd_onehot[rd] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/rf_write_arbiter_arb.sv
// Two-input grant logic: round-robin on the last winner, or fixed priority
// to requester 0. A lone requester always wins.
module rr_arb2
    import rf_write_arbiter_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  last_e              last_i,
    output logic [NUM_REQ-1:0] grant_o
);

    // Resolve contention; otherwise pass the single valid through.
    always_comb begin
        grant_o = valid_i;
        if (&valid_i) begin
            if ((RR_EN != 0) && (last_i == LAST0)) begin
                grant_o = 2'b10;
            end else begin
                grant_o = 2'b01;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: merges ALU (0) and load (1) writebacks into a
// single write port through a one-entry output stage that freezes on hold.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    input  logic [RD_W-1:0]     req0_rd,
    input  logic [DATA_W-1:0]   req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [RD_W-1:0]     req1_rd,
    input  logic [DATA_W-1:0]   req1_data,
    output logic                req1_ready,
    input  logic                hold,
    output logic                wr_en,
    output logic [RD_W-1:0]     wr_rd,
    output logic [DATA_W-1:0]   wr_data,
    output logic [NUM_REGS-1:0] pending
);

    stage_t              stg_q, stg_d;
    last_e               last_q, last_d;
    logic [NUM_REQ-1:0]  valid_vec;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  ready_vec;
    logic [NUM_REQ-1:0]  accept_vec;
    logic                stg_drain;
    logic                stg_open;

    assign valid_vec = {req1_valid, req0_valid};

    rr_arb2 #(
        .RR_EN(RR_EN)
    ) u_arb (
        .valid_i (valid_vec),
        .last_i  (last_q),
        .grant_o (grant)
    );

    // The stage can take a new entry when it is empty or emptying this cycle.
    assign stg_drain  = stg_q.valid & ~hold;
    assign stg_open   = ~stg_q.valid | ~hold;
    assign accept_vec = ready_vec & valid_vec;

    // Arbiter state register; reset leaves requester 0 first in line.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= LAST1;
        end else begin
            last_q <= last_d;
        end
    end

    // Next arbiter state: remember the winner, keep state when nothing is granted.
    always_comb begin
        last_d = last_q;
        if (accept_vec[0]) begin
            last_d = LAST0;
        end else if (accept_vec[1]) begin
            last_d = LAST1;
        end
    end

    // Readies: grants only while the stage can accept and never during reset.
    always_comb begin
        ready_vec = '0;
        if (!reset && stg_open) begin
            ready_vec = grant;
        end
        req0_ready = ready_vec[0];
        req1_ready = ready_vec[1];
    end

    // Stage next state: drain first, then load the accepted request on top.
    always_comb begin
        stg_d = stg_q;
        if (stg_drain) begin
            stg_d.valid = 1'b0;
        end
        if (accept_vec[1]) begin
            stg_d = '{valid: 1'b1, rd: req1_rd, data: req1_data};
        end else if (accept_vec[0]) begin
            stg_d = '{valid: 1'b1, rd: req0_rd, data: req0_data};
        end
    end

    // Stage register; reset drops any in-flight entry without committing it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_q <= '0;
        end else begin
            stg_q <= stg_d;
        end
    end

    // Register-file write port and pending map; x0 writes are silent.
    always_comb begin
        wr_rd   = stg_q.rd;
        wr_data = stg_q.data;
        wr_en   = stg_q.valid & ~hold & (stg_q.rd != '0) & ~reset;
        pending = '0;
        if (stg_q.valid && !reset) begin
            pending = rd_onehot(stg_q.rd);
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a round-robin and a fixed-priority
// instance share the same stimulus; each vector is one clock cycle.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, hold = 1'b0;
    logic [4:0]  req0_rd = '0, req1_rd = '0;
    logic [31:0] req0_data = '0, req1_data = '0;

    logic        rr_r0, rr_r1, rr_we;
    logic [4:0]  rr_rd;
    logic [31:0] rr_data, rr_pend;
    logic        fp_r0, fp_r1, fp_we;
    logic [4:0]  fp_rd;
    logic [31:0] fp_data, fp_pend;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.RR_EN(1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(rr_r0),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(rr_r1),
        .hold(hold), .wr_en(rr_we), .wr_rd(rr_rd), .wr_data(rr_data), .pending(rr_pend)
    );

    rf_write_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(fp_r0),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(fp_r1),
        .hold(hold), .wr_en(fp_we), .wr_rd(fp_rd), .wr_data(fp_data), .pending(fp_pend)
    );

    typedef struct {
        bit          rst;
        bit          v0;
        logic [4:0]  rd0;
        logic [31:0] d0;
        bit          v1;
        logic [4:0]  rd1;
        logic [31:0] d1;
        bit          hold;
        bit          e_r0;
        bit          e_r1;
        bit          e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic [31:0] e_pend;
        bit          chk_wr;
        bit          fp;
    } vec_t;

    function automatic vec_t mk(bit rst, bit v0, logic [4:0] rd0, logic [31:0] d0,
                                bit v1, logic [4:0] rd1, logic [31:0] d1, bit hld,
                                bit r0, bit r1, bit we, logic [4:0] rd, logic [31:0] data,
                                logic [31:0] pend, bit chk_wr, bit fp);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.rd0 = rd0; v.d0 = d0;
        v.v1 = v1; v.rd1 = rd1; v.d1 = d1; v.hold = hld;
        v.e_r0 = r0; v.e_r1 = r1; v.e_we = we; v.e_rd = rd; v.e_data = data;
        v.e_pend = pend; v.chk_wr = chk_wr; v.fp = fp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, check outputs 1ns later.
    task automatic step(input vec_t v, input string tag);
        logic        a_r0, a_r1, a_we;
        logic [4:0]  a_rd;
        logic [31:0] a_data, a_pend;
        @(negedge clk);
        reset = v.rst; hold = v.hold;
        req0_valid = v.v0; req0_rd = v.rd0; req0_data = v.d0;
        req1_valid = v.v1; req1_rd = v.rd1; req1_data = v.d1;
        #1;
        a_r0 = v.fp ? fp_r0 : rr_r0;
        a_r1 = v.fp ? fp_r1 : rr_r1;
        a_we = v.fp ? fp_we : rr_we;
        a_rd = v.fp ? fp_rd : rr_rd;
        a_data = v.fp ? fp_data : rr_data;
        a_pend = v.fp ? fp_pend : rr_pend;
        chk({tag, " req0_ready"}, {31'd0, a_r0}, {31'd0, v.e_r0});
        chk({tag, " req1_ready"}, {31'd0, a_r1}, {31'd0, v.e_r1});
        chk({tag, " wr_en"}, {31'd0, a_we}, {31'd0, v.e_we});
        chk({tag, " pending"}, a_pend, v.e_pend);
        if (v.chk_wr) begin
            chk({tag, " wr_rd"}, {27'd0, a_rd}, {27'd0, v.e_rd});
            chk({tag, " wr_data"}, a_data, v.e_data);
        end
        $display("[TB] %s rst=%0b v0=%0b v1=%0b hold=%0b -> r0=%0b r1=%0b we=%0b rd=%0d data=%0h pend=%0h",
                 tag, v.rst, v.v0, v.v1, v.hold, a_r0, a_r1, a_we, a_rd, a_data, a_pend);
    endtask

    vec_t tbl[16];

    initial begin
        //               rst v0 rd0 d0            v1 rd1 d1       hld r0 r1 we rd  data           pend          chk fp
        tbl[0]  = mk(1, 0, 0, 0,             0, 0, 0,         0,  0, 0, 0, 0,  0,             0,            0, 0);
        tbl[1]  = mk(1, 1, 5, 32'hDEADBEEF,  1, 2, 32'h22,    0,  0, 0, 0, 0,  0,             0,            1, 0);
        tbl[2]  = mk(0, 1, 5, 32'hDEADBEEF,  0, 0, 0,         0,  1, 0, 0, 0,  0,             0,            1, 0);
        tbl[3]  = mk(0, 0, 0, 0,             0, 0, 0,         0,  0, 0, 1, 5,  32'hDEADBEEF,  32'h20,       1, 0);
        tbl[4]  = mk(1, 0, 0, 0,             0, 0, 0,         0,  0, 0, 0, 0,  0,             0,            0, 0);
        tbl[5]  = mk(0, 1, 1, 32'h11,        1, 2, 32'h22,    0,  1, 0, 0, 0,  0,             0,            1, 0);
        tbl[6]  = mk(0, 1, 1, 32'h11,        1, 2, 32'h22,    0,  0, 1, 1, 1,  32'h11,        32'h2,        1, 0);
        tbl[7]  = mk(0, 1, 1, 32'h11,        1, 2, 32'h22,    0,  1, 0, 1, 2,  32'h22,        32'h4,        1, 0);
        tbl[8]  = mk(0, 1, 1, 32'h11,        1, 2, 32'h22,    0,  0, 1, 1, 1,  32'h11,        32'h2,        1, 0);
        tbl[9]  = mk(0, 0, 0, 0,             0, 0, 0,         0,  0, 0, 1, 2,  32'h22,        32'h4,        1, 0);
        tbl[10] = mk(0, 0, 0, 0,             1, 0, 32'h1234,  0,  0, 1, 0, 0,  0,             0,            0, 0);
        tbl[11] = mk(0, 0, 0, 0,             0, 0, 0,         0,  0, 0, 0, 0,  32'h1234,      0,            1, 0);
        tbl[12] = mk(0, 0, 0, 0,             1, 31, 32'hA5A5A5A5, 1, 0, 1, 0, 0, 0,            0,            0, 0);
        tbl[13] = mk(0, 0, 0, 0,             0, 0, 0,         1,  0, 0, 0, 31, 32'hA5A5A5A5,  32'h80000000, 1, 0);
        tbl[14] = mk(0, 0, 0, 0,             0, 0, 0,         0,  0, 0, 1, 31, 32'hA5A5A5A5,  32'h80000000, 1, 0);
        tbl[15] = mk(0, 0, 0, 0,             0, 0, 0,         0,  0, 0, 0, 0,  0,             0,            0, 0);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Hold with a full stage: rd 7 stays pending, readies drop, then commits
        // on release while req0's next write is accepted in the same cycle.
        step(mk(1, 0, 0, 0,     0, 0, 0, 0,  0, 0, 0, 0, 0,      0,      0, 0), "hold_rst");
        step(mk(0, 1, 7, 32'h77, 0, 0, 0, 0,  1, 0, 0, 0, 0,      0,      1, 0), "hold_acc");
        for (int c = 0; c < 3; c++) begin
            step(mk(0, 1, 8, 32'h88, 0, 0, 0, 1, 0, 0, 0, 7, 32'h77, 32'h80, 1, 0),
                 $sformatf("hold_c%0d", c));
        end
        step(mk(0, 1, 8, 32'h88, 0, 0, 0, 0,  1, 0, 1, 7, 32'h77, 32'h80,  1, 0), "hold_rel");
        step(mk(0, 0, 0, 0,      0, 0, 0, 0,  0, 0, 1, 8, 32'h88, 32'h100, 1, 0), "hold_next");

        // Reset during an in-flight write and contention: rd 9 is dropped and
        // requester 0 wins the first post-reset contention.
        step(mk(0, 1, 9, 32'h99, 0, 0, 0,     0, 1, 0, 0, 0, 0,     0,     0, 0), "rst_acc");
        step(mk(1, 1, 3, 32'h33, 1, 4, 32'h44, 0, 0, 0, 0, 0, 0,     0,     0, 0), "rst_mid");
        step(mk(0, 1, 3, 32'h33, 1, 4, 32'h44, 0, 1, 0, 0, 0, 0,     0,     1, 0), "rst_grant");
        step(mk(0, 0, 0, 0,      0, 0, 0,     0, 0, 0, 1, 3, 32'h33, 32'h8, 1, 0), "rst_commit");

        // Fixed-priority instance: requester 0 takes every contended cycle.
        step(mk(1, 0, 0, 0,      0, 0, 0,     0, 0, 0, 0, 0, 0,     0,     0, 1), "fp_rst");
        step(mk(0, 1, 1, 32'h11, 1, 2, 32'h22, 0, 1, 0, 0, 0, 0,     0,     1, 1), "fp_c0");
        step(mk(0, 1, 1, 32'h11, 1, 2, 32'h22, 0, 1, 0, 1, 1, 32'h11, 32'h2, 1, 1), "fp_c1");
        step(mk(0, 1, 1, 32'h11, 1, 2, 32'h22, 0, 1, 0, 1, 1, 32'h11, 32'h2, 1, 1), "fp_c2");
        step(mk(0, 0, 0, 0,      0, 0, 0,     0, 0, 0, 1, 1, 32'h11, 32'h2, 1, 1), "fp_tail");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority to requester 0.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have req0_valid  input  1  requester 0 (ALU writeback) has a write.
REQ-005 SHALL have req0_rd  input  5  requester 0 destination register.
REQ-006 SHALL have req0_data  input  32  requester 0 write data.
REQ-007 SHALL have req0_ready  output  1  requester 0 write accepted this cycle.
REQ-008 SHALL have req1_valid, req1_rd, req1_data, req1_ready with widths 1/5/32/1, same meaning for requester 1 (load writeback).
REQ-009 SHALL have hold  input  1  register file unavailable; output stage frozen.
REQ-010 SHALL have wr_en  output  1  write strobe to register file write_enable.
REQ-011 SHALL have wr_rd  output  5  register file rd.
REQ-012 SHALL have wr_data  output  32  register file rd_din.
REQ-013 SHALL have pending  output  32  bit i set = accepted write to xi not yet committed.

Function
REQ-014 SHALL hold one output stage (stg_valid, stg_rd, stg_data); stage drains in a cycle when stg_valid and not hold.
REQ-015 SHALL accept a request in a cycle only when stage is empty or draining; acceptance = valid and ready both high at the edge.
REQ-016 SHALL assert at most one of req0_ready/req1_ready per cycle; ready SHALL depend combinationally on valids, hold, stage state and arbiter state only.
REQ-017 SHALL keep arbiter state LAST0/LAST1 (last granted requester); reset state LAST1 so requester 0 wins the first contention.
REQ-018 With RR_EN=1 and both valid, SHALL grant the requester not equal to LAST; on a grant, LAST <= granted index; no grant leaves LAST unchanged.
REQ-019 With RR_EN=0, SHALL always grant requester 0 when both valid; LAST unused.
REQ-020 With one valid, SHALL grant it regardless of LAST.
REQ-021 Latency: request accepted at edge N SHALL produce wr_en=1 with its rd/data during cycle N+1 (committed at edge N+1) if hold=0; each cycle of hold delays commit by one cycle.
REQ-022 wr_en SHALL equal stg_valid & ~hold & (stg_rd != 0); wr_rd/wr_data SHALL equal stg_rd/stg_data at all times.
REQ-023 Writes with rd=0 SHALL be accepted and drained normally but never strobe wr_en and never set pending.
REQ-024 pending SHALL be a one-hot-or-zero decode of stg_rd when stg_valid and stg_rd != 0, else zero; pending[0] SHALL always be 0.
REQ-025 Back-to-back writes to same rd SHALL commit in grant order; last granted value SHALL be final.
REQ-026 hold asserted SHALL freeze stage contents and LAST and deassert both readies when stage is full.
REQ-027 hold asserted with stage empty SHALL still allow one acceptance into stage.

Reset
REQ-028 reset SHALL clear stg_valid, stg_rd, stg_data, set LAST=LAST1, drop any in-flight stage entry without committing; during reset cycle wr_en, readies and pending SHALL be 0.
REQ-029 Reset mid-hold or mid-contention SHALL discard state identically; first post-reset grant follows REQ-017.

Structure
REQ-030 Requester count (2), register index width (5), data width (32) and arbiter state encoding SHALL live in the shared CPU package.
REQ-031 Grant logic SHALL be one sub-module rr_arb2 (valids, last -> grant one-hot); stage and pending decode stay in rf_write_arbiter.

Verification
REQ-032 Single request: req0 rd=5 data=0xDEADBEEF, hold=0 -> req0_ready=1 at cycle 0; cycle 1 wr_en=1, wr_rd=5, wr_data=0xDEADBEEF, pending=0x20.
REQ-033 Contention RR_EN=1: both valid for 4 cycles (req0 rd=1, req1 rd=2) after reset -> grants 0,1,0,1; wr_rd sequence 1,2,1,2.
REQ-034 Fixed priority RR_EN=0: both valid 3 cycles -> req0 granted every cycle, req1_ready stays 0.
REQ-035 x0 write: req1 rd=0 data=0x1234 -> req1_ready=1, next cycle wr_en=0, pending=0.
REQ-036 Hold: accept rd=7, then hold=1 for 3 cycles with req0 valid -> wr_en=0, ready=0, pending=0x80 throughout; hold drop -> rd 7 commits, req0 accepted same cycle.
REQ-037 Reset mid-flight: accept rd=9 then reset at next edge -> no wr_en for rd 9, pending=0, next contention grants req0.
